// File: rtl/captura_operandos_pkg.sv
// Shared constants for the operand-entry stage: operand width, default debounce
// length and the FSM state codes shown on the LEDs.
package captura_operandos_pkg;

  localparam int W_OP           = 4;
  localparam int DEB_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    CARGA_A = 2'b00,
    CARGA_B = 2'b01,
    LISTO   = 2'b10
  } estado_t;

endpackage

// File: rtl/captura_operandos_antirrebote.sv
// Button conditioning: 2-FF synchronizer, debounce counter and registered
// single-cycle rising-edge pulse on the debounced level.
module antirrebote
  import captura_operandos_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulso
);

  localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q;
  logic          pulso_q;

  // Counter only advances while the synchronized level disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = sync_q[1];
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulso_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_in};
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulso_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/captura_operandos.sv
// Operand-entry stage for the 4-bit ripple adder: loads A then B from switches
// on debounced cargar presses. Optional carry-in toggle button under CIN_BTN_EN.
module captura_operandos
  import captura_operandos_pkg::*;
#(
  parameter int W          = W_OP,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         btn_cargar,
  input  logic         btn_borrar,
`ifdef CIN_BTN_EN
  input  logic         btn_cin,
`endif
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic         cin,
  output logic         valido,
  output logic [1:0]   estado
);

  logic p_cargar, p_borrar;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cargar (
    .clk(clk), .rst(rst), .btn_in(btn_cargar), .pulso(p_cargar)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_borrar (
    .clk(clk), .rst(rst), .btn_in(btn_borrar), .pulso(p_borrar)
  );

  estado_t        state_q, state_d;
  logic [W-1:0]   num1_q, num1_d;
  logic [W-1:0]   num2_q, num2_d;
  logic           valido_q, valido_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CARGA_A;
      num1_q   <= '0;
      num2_q   <= '0;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      valido_q <= valido_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    case (state_q)
      CARGA_A: if (p_cargar) begin
        num1_d  = sw;
        state_d = CARGA_B;
      end
      CARGA_B: if (p_cargar) begin
        num2_d  = sw;
        state_d = LISTO;
      end
      LISTO: if (p_cargar) begin
        num1_d  = sw;
        num2_d  = '0;
        state_d = CARGA_B;
      end
      default: state_d = CARGA_A;
    endcase
    // Clear overrides any load that lands in the same cycle.
    if (p_borrar) begin
      num1_d  = '0;
      num2_d  = '0;
      state_d = CARGA_A;
    end
    valido_d = (state_d == LISTO);
  end

`ifdef CIN_BTN_EN
  logic p_cin;
  logic cin_q;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cin (
    .clk(clk), .rst(rst), .btn_in(btn_cin), .pulso(p_cin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cin_q <= 1'b0;
    else if (p_cin) cin_q <= ~cin_q;
  end

  assign cin = cin_q;
`else
  assign cin = 1'b0;
`endif

  assign num1   = num1_q;
  assign num2   = num2_q;
  assign valido = valido_q;
  assign estado = state_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Self-checking bench for captura_operandos with DEB_CYCLES=4: a press-level
// model checked every cycle plus directed literal expectations.
module tb_captura_operandos;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_cargar = 1'b0;
  logic         btn_borrar = 1'b0;
  logic         btn_cin = 1'b0;
  logic [W-1:0] num1, num2;
  logic         cin, valido;
  logic [1:0]   estado;

  int n_checks = 0;
  int n_errors = 0;

  captura_operandos #(.W(W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_cargar(btn_cargar), .btn_borrar(btn_borrar),
`ifdef CIN_BTN_EN
    .btn_cin(btn_cin),
`endif
    .num1(num1), .num2(num2), .cin(cin), .valido(valido), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press is accepted once DEB consecutive raw samples disagree with
  // the accepted level; its effect appears 4 edges after the last of them.
  int         m_num1, m_num2, m_st, m_cin;
  int         run_len [3];
  bit         lvl     [3];
  bit [3:0]   pipe    [3];

  initial begin
    bit raw [3];
    bit act_c, act_b, act_t, rise;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_num1 = 0; m_num2 = 0; m_st = 0; m_cin = 0;
        for (int b = 0; b < 3; b++) begin
          run_len[b] = 0; lvl[b] = 0; pipe[b] = '0;
        end
      end else begin
        act_c = pipe[0][3];
        act_b = pipe[1][3];
        act_t = pipe[2][3];
        if (act_b) begin
          m_num1 = 0; m_num2 = 0; m_st = 0;
        end else if (act_c) begin
          if (m_st == 0)      begin m_num1 = int'(sw); m_st = 1; end
          else if (m_st == 1) begin m_num2 = int'(sw); m_st = 2; end
          else                begin m_num1 = int'(sw); m_num2 = 0; m_st = 1; end
        end
`ifdef CIN_BTN_EN
        if (act_t) m_cin = 1 - m_cin;
`endif
        raw[0] = btn_cargar; raw[1] = btn_borrar; raw[2] = btn_cin;
        for (int b = 0; b < 3; b++) begin
          rise = 1'b0;
          if (raw[b] != lvl[b]) begin
            run_len[b]++;
            if (run_len[b] == DEB) begin
              lvl[b] = raw[b];
              run_len[b] = 0;
              rise = raw[b];
            end
          end else begin
            run_len[b] = 0;
          end
          pipe[b] = {pipe[b][2:0], rise};
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cyc_num1",   int'(num1),   m_num1);
        chk("cyc_num2",   int'(num2),   m_num2);
        chk("cyc_cin",    int'(cin),    m_cin);
        chk("cyc_valido", int'(valido), (m_st == 2) ? 1 : 0);
        chk("cyc_estado", int'(estado), m_st);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input bit v);
    case (which)
      0: btn_cargar = v;
      1: btn_borrar = v;
      default: btn_cin = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    idle(hold);
    set_btn(which, 1'b0);
    idle(12);
  endtask

  initial begin
    int lat;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("rst_num1",   int'(num1),   0);
    chk("rst_num2",   int'(num2),   0);
    chk("rst_cin",    int'(cin),    0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_estado", int'(estado), 0);

    // reset in the middle of a press discards it
    sw = 4'h5;
    btn_cargar = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(2);
    btn_cargar = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(12);
    chk("rstpress_num1",   int'(num1),   0);
    chk("rstpress_estado", int'(estado), 0);

    // normal entry with latency measurement
    sw = 4'hA;
    btn_cargar = 1'b1;
    lat = -1;
    for (int e = 0; e < 20 && lat < 0; e++) begin
      @(posedge clk);
      #1;
      if (num1 == 4'hA) lat = e;
    end
    chk("latencia_carga", lat, 7);
    idle(3);
    btn_cargar = 1'b0;
    idle(12);
    chk("entrada_a_num1",   int'(num1),   4'hA);
    chk("entrada_a_estado", int'(estado), 1);
    sw = 4'h7;
    press(0, 10);
    chk("entrada_num1",   int'(num1),   4'hA);
    chk("entrada_num2",   int'(num2),   4'h7);
    chk("entrada_valido", int'(valido), 1);
    chk("entrada_estado", int'(estado), 2);

    // bounce shorter than the debounce window
    sw = 4'hE;
    for (int i = 0; i < 10; i++) begin
      btn_cargar = ~btn_cargar;
      idle(2);
    end
    btn_cargar = 1'b0;
    idle(12);
    chk("rebote_num1",   int'(num1),   4'hA);
    chk("rebote_num2",   int'(num2),   4'h7);
    chk("rebote_estado", int'(estado), 2);

    // long hold from LISTO loads exactly once
    sw = 4'h3;
    press(0, 100);
    chk("mantener_num1",   int'(num1),   4'h3);
    chk("mantener_num2",   int'(num2),   0);
    chk("mantener_estado", int'(estado), 1);
    chk("mantener_valido", int'(valido), 0);

    sw = 4'h9;
    press(0, 10);
    chk("reentrada_num2",   int'(num2),   4'h9);
    chk("reentrada_estado", int'(estado), 2);

    // simultaneous cargar and borrar: clear wins
    sw = 4'hF;
    btn_cargar = 1'b1;
    btn_borrar = 1'b1;
    idle(10);
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;
    idle(12);
    chk("prioridad_num1",   int'(num1),   0);
    chk("prioridad_num2",   int'(num2),   0);
    chk("prioridad_estado", int'(estado), 0);

`ifdef CIN_BTN_EN
    press(2, 8);
    chk("cin_1", int'(cin), 1);
    press(2, 8);
    chk("cin_2", int'(cin), 0);
    press(2, 8);
    chk("cin_3", int'(cin), 1);
    press(1, 8);
    chk("cin_borrar", int'(cin), 1);
`else
    press(2, 8);
    chk("cin_fijo", int'(cin), 0);
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
Upstream operand-entry stage for the 4-bit ripple adder. Loads two 4-bit operands in sequence from board switches, gated by a debounced push button. Holds the operands stable for the adder and flags when both are valid. An optional carry-in toggle button is available. Outputs drive the adder's operand and carry-in inputs directly.

Parameters:
W, 4, operand width in bits; must match the adder width.
DEB_CYCLES, 500000, number of consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
sw  input  W  raw switch value to be loaded; asynchronous, but must be static while a button is pressed
btn_cargar  input  1  raw load push button, active-high, asynchronous
btn_borrar  input  1  raw clear push button, active-high, asynchronous
num1  output  W  operand A, registered
num2  output  W  operand B, registered
cin  output  1  carry-in to adder, registered
valido  output  1  high while both operands are loaded (state LISTO)
estado  output  2  current FSM state code, for LEDs

Behaviour:
- Reset (async, active-high):
  - num1=0, num2=0, cin=0, valido=0, estado=CARGA_A.
  - All synchronizers, debounce counters and debounced levels clear to 0.
  - Reset asserted mid-press: the press is discarded. After release of rst, the button must be seen stable-high for DEB_CYCLES before it counts.
- Each button passes through the same conditioning chain:
  - 2-FF synchronizer.
  - Debounce: a counter runs while the synchronized level differs from the debounced level and clears whenever they are equal. When it reaches DEB_CYCLES-1, the debounced level updates.
  - Rising-edge detector on the debounced level gives a single-cycle pulse.
  - Bounces shorter than DEB_CYCLES produce no pulse.
  - A held button produces exactly one pulse.
- Latency: the raw rising edge is first sampled on edge 0. The pulse is high in the cycle after edge DEB_CYCLES+2. The register/state update is visible after edge DEB_CYCLES+3.
- FSM states (estado encoding): CARGA_A=2'b00, CARGA_B=2'b01, LISTO=2'b10; 2'b11 is unused and recovers to CARGA_A.
  - CARGA_A, cargar pulse: num1<=sw, go to CARGA_B.
  - CARGA_B, cargar pulse: num2<=sw, go to LISTO.
  - LISTO, cargar pulse: num1<=sw, num2<=0, go to CARGA_B (start a new entry).
  - Any state, borrar pulse: num1<=0, num2<=0, go to CARGA_A. cin is unaffected.
  - cargar and borrar pulses in the same cycle: borrar wins.
- valido is a registered output, equal to (estado==LISTO). It rises in the same cycle num2 updates.
- Operands are never modified without a pulse. sw is sampled only in the pulse cycle.

Optional Feature:
CIN_BTN_EN
- Defined:
  - Adds input port btn_cin (1 bit, raw, active-high).
  - btn_cin is conditioned identically to the other buttons.
  - Each pulse toggles cin, in any state.
  - cin is cleared by rst only, not by borrar.
- Undefined:
  - btn_cin port is absent.
  - cin is a constant 0.

Decomposition:
- Shared package: state constants CARGA_A, CARGA_B, LISTO; default DEB_CYCLES; operand width W.
- One sub-module: antirrebote (synchronizer + debounce counter + rising-edge pulse; parameter DEB_CYCLES; ports clk, rst, btn_in, pulso).
  - Instantiated two times, or three with CIN_BTN_EN.
  - Debounce counter width is $clog2(DEB_CYCLES).

Test Plan (bench uses DEB_CYCLES=4):
- Reset: after rst, num1=0, num2=0, cin=0, valido=0, estado=00. Assert rst mid-press: no load occurs after release.
- Normal entry: sw=4'hA, press cargar 10 cycles, release; sw=4'h7, press again → num1=A, num2=7, valido=1, estado=10. The first update occurs exactly 7 edges after the first sampled high.
- Bounce rejection: cargar toggles every 2 cycles for 20 cycles, then settles low → no state change, num1 unchanged.
- Hold and re-entry: in LISTO, hold cargar 100 cycles with sw=4'h3 → exactly one load: num1=3, num2=0, estado=01, valido=0.
- Priority: cargar and borrar rise in the same cycle (identical pulses) from LISTO → num1=0, num2=0, estado=00.
- CIN_BTN_EN defined: three btn_cin presses → cin goes 1, 0, 1. A borrar press leaves cin=1. Undefined: cin stays 0 throughout.
